execute_stage: RTL and testbench

- Pipeline EX stage that sits directly downstream of the ALU decoder.
- Consumes the 3-bit ALU control code plus operands, forwarding selects and control bits from the decode side.
- Computes the ALU result, branch decision and branch target.
- Registers the result into the EX/MEM boundary register, using a valid/ready handshake with stall and flush.

---
 rtl/execute_stage_pkg.sv | 15 +
 rtl/execute_stage_alu.sv | 35 +++
 rtl/execute_stage.sv | 155 +++++++++++++++
 tb/tb_execute_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the EX stage: ALU operation codes (as emitted by the
// ALU decoder) and forwarding-select codes (as emitted by the hazard unit).
package execute_stage_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the EX stage. Zero always reflects SrcA - SrcB so the
// branch comparison works regardless of which operation is selected.
module execute_stage_alu
   import execute_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] SrcA_i,
   input  logic [XLEN-1:0] SrcB_i,
   input  logic [2:0]      ALUControl_i,
   output logic [XLEN-1:0] ALUResult_o,
   output logic            Zero_o
);

   logic [XLEN-1:0] diff;
   logic            lt;

   assign diff   = SrcA_i - SrcB_i;
   assign Zero_o = (diff == '0);
   assign lt     = ($signed(SrcA_i) < $signed(SrcB_i));

   // Operation select; unused codes yield zero
   always_comb begin
      ALUResult_o = '0;
      case (ALUControl_i)
         ALU_ADD: ALUResult_o = SrcA_i + SrcB_i;
         ALU_SUB: ALUResult_o = diff;
         ALU_AND: ALUResult_o = SrcA_i & SrcB_i;
         ALU_OR:  ALUResult_o = SrcA_i | SrcB_i;
         ALU_SLT: ALUResult_o = {{(XLEN-1){1'b0}}, lt};
         default: ALUResult_o = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// EX pipeline stage: operand forwarding, ALU, branch resolution and the
// single-entry EX/MEM boundary register with valid/ready, stall and flush.
module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            ALUControl,
   input  logic                  ALUSrc,
   input  logic [1:0]            ForwardA,
   input  logic [1:0]            ForwardB,
   input  logic [XLEN-1:0]       RD1,
   input  logic [XLEN-1:0]       RD2,
   input  logic [XLEN-1:0]       ImmExt,
   input  logic [XLEN-1:0]       PC,
   input  logic [XLEN-1:0]       PCPlus4,
   input  logic [XLEN-1:0]       ResultW,
   input  logic [REG_ADDR_W-1:0] RdE,
   input  logic                  RegWriteE,
   input  logic                  MemWriteE,
   input  logic                  BranchE,
   input  logic                  JumpE,
   input  logic [1:0]            ResultSrcE,
   output logic                  PCSrcE,
   output logic [XLEN-1:0]       PCTargetE,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       ALUResultM,
   output logic [XLEN-1:0]       WriteDataM,
   output logic [XLEN-1:0]       PCPlus4M,
   output logic [REG_ADDR_W-1:0] RdM,
   output logic                  RegWriteM,
   output logic                  MemWriteM,
   output logic [1:0]            ResultSrcM
);

   logic [XLEN-1:0]       src_a, fwd_b, src_b, alu_result;
   logic                  zero, load, capture, drain;

   logic                  valid_q, valid_d;
   logic [XLEN-1:0]       alu_q, alu_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;
   logic [XLEN-1:0]       pc4_q, pc4_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic                  regw_q, regw_d;
   logic                  memw_q, memw_d;
   logic [1:0]            rsrc_q, rsrc_d;

   // Operand A forwarding; code 11 aliases the register-file value
   always_comb begin
      case (ForwardA)
         FWD_WB:  src_a = ResultW;
         FWD_MEM: src_a = alu_q;
         default: src_a = RD1;
      endcase
   end

   // Operand B forwarding; the forwarded value is also the store data
   always_comb begin
      case (ForwardB)
         FWD_WB:  fwd_b = ResultW;
         FWD_MEM: fwd_b = alu_q;
         default: fwd_b = RD2;
      endcase
   end

   assign src_b = ALUSrc ? ImmExt : fwd_b;

   execute_stage_alu #(
      .XLEN(XLEN)
   ) u_alu (
      .SrcA_i      (src_a),
      .SrcB_i      (src_b),
      .ALUControl_i(ALUControl),
      .ALUResult_o (alu_result),
      .Zero_o      (zero)
   );

   assign PCTargetE = PC + ImmExt;

   // Single entry, no skid buffer: accept when empty or when draining this edge
   assign in_ready = ~valid_q | out_ready;
   assign load     = in_valid & in_ready;
   assign capture  = load & ~flush;
   assign drain    = valid_q & out_ready;

   // Redirect only for an instruction that actually enters the register
   assign PCSrcE = capture & ((BranchE & zero) | JumpE);

   // Next-state for the EX/MEM register: capture, bubble, drain or hold
   always_comb begin
      valid_d = valid_q;
      alu_d   = alu_q;
      wdata_d = wdata_q;
      pc4_d   = pc4_q;
      rd_d    = rd_q;
      regw_d  = regw_q;
      memw_d  = memw_q;
      rsrc_d  = rsrc_q;
      if (capture) begin
         valid_d = 1'b1;
         alu_d   = alu_result;
         wdata_d = fwd_b;
         pc4_d   = PCPlus4;
         rd_d    = RdE;
         regw_d  = RegWriteE;
         memw_d  = MemWriteE;
         rsrc_d  = ResultSrcE;
      end else if (load | drain) begin
         // Flushed accept or plain drain: leave a bubble with write enables low
         valid_d = 1'b0;
         regw_d  = 1'b0;
         memw_d  = 1'b0;
      end
   end

   // EX/MEM register with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         alu_q   <= '0;
         wdata_q <= '0;
         pc4_q   <= '0;
         rd_q    <= '0;
         regw_q  <= 1'b0;
         memw_q  <= 1'b0;
         rsrc_q  <= '0;
      end else begin
         valid_q <= valid_d;
         alu_q   <= alu_d;
         wdata_q <= wdata_d;
         pc4_q   <= pc4_d;
         rd_q    <= rd_d;
         regw_q  <= regw_d;
         memw_q  <= memw_d;
         rsrc_q  <= rsrc_d;
      end
   end

   assign out_valid  = valid_q;
   assign ALUResultM = alu_q;
   assign WriteDataM = wdata_q;
   assign PCPlus4M   = pc4_q;
   assign RdM        = rd_q;
   assign RegWriteM  = regw_q;
   assign MemWriteM  = memw_q;
   assign ResultSrcM = rsrc_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios followed by random traffic,
// all checked against a one-slot behavioural model of the EX/MEM boundary.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, in_valid, in_ready;
   logic [2:0]  ALUControl;
   logic        ALUSrc;
   logic [1:0]  ForwardA, ForwardB;
   logic [31:0] RD1, RD2, ImmExt, PC, PCPlus4, ResultW;
   logic [4:0]  RdE;
   logic        RegWriteE, MemWriteE, BranchE, JumpE;
   logic [1:0]  ResultSrcE;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        out_valid, out_ready;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;

   int checks = 0;
   int errors = 0;

   // Model of the boundary slot: what MEM should currently see
   bit          m_valid;
   logic [31:0] m_alu, m_wd, m_pc4;
   logic [4:0]  m_rd;
   bit          m_rw, m_mw;
   logic [1:0]  m_rs;

   execute_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .ALUControl(ALUControl), .ALUSrc(ALUSrc), .ForwardA(ForwardA), .ForwardB(ForwardB),
      .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt), .PC(PC), .PCPlus4(PCPlus4), .ResultW(ResultW),
      .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .out_valid(out_valid), .out_ready(out_ready),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
      if (sel == 2'b01) return ResultW;
      if (sel == 2'b10) return m_alu;
      return rf;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_alu = '0; m_wd = '0; m_pc4 = '0; m_rd = '0;
      m_rw = 0; m_mw = 0; m_rs = '0;
   endtask

   task automatic idle_inputs();
      flush = 0; in_valid = 0; ALUControl = 3'd0; ALUSrc = 0; ForwardA = 2'b00; ForwardB = 2'b00;
      RD1 = '0; RD2 = '0; ImmExt = '0; PC = '0; PCPlus4 = '0; ResultW = '0; RdE = '0;
      RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0; ResultSrcE = '0; out_ready = 1;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, ".RegWriteM"}, 32'(RegWriteM), 32'(m_rw));
      chk({tag, ".MemWriteM"}, 32'(MemWriteM), 32'(m_mw));
      if (m_valid) begin
         chk({tag, ".ALUResultM"}, ALUResultM, m_alu);
         chk({tag, ".WriteDataM"}, WriteDataM, m_wd);
         chk({tag, ".PCPlus4M"}, PCPlus4M, m_pc4);
         chk({tag, ".RdM"}, 32'(RdM), 32'(m_rd));
         chk({tag, ".ResultSrcM"}, 32'(ResultSrcM), 32'(m_rs));
      end
   endtask

   // Called just after a falling edge with inputs already applied
   task automatic step(input string tag);
      logic [31:0] a, fb, b, res;
      bit rdy, acc, taken;
      #1;
      a     = pick(ForwardA, RD1);
      fb    = pick(ForwardB, RD2);
      b     = ALUSrc ? ImmExt : fb;
      res   = ref_alu(ALUControl, a, b);
      rdy   = !m_valid || out_ready;
      acc   = in_valid && rdy;
      taken = acc && !flush && ((BranchE && (a == b)) || JumpE);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
      chk({tag, ".PCTargetE"}, PCTargetE, PC + ImmExt);
      chk({tag, ".PCSrcE"}, 32'(PCSrcE), 32'(taken));
      @(posedge clk);
      if (acc && !flush) begin
         m_valid = 1; m_alu = res; m_wd = fb; m_pc4 = PCPlus4; m_rd = RdE;
         m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE;
      end else if (acc || (m_valid && out_ready)) begin
         m_valid = 0; m_rw = 0; m_mw = 0;
      end
      #1;
      check_regs(tag);
      @(negedge clk);
   endtask

   task automatic op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] imm, input bit src);
      in_valid = 1; flush = 0; ALUControl = c; RD1 = a; RD2 = b; ImmExt = imm; ALUSrc = src;
      ForwardA = 2'b00; ForwardB = 2'b00; BranchE = 0; JumpE = 0;
      RegWriteE = 1; MemWriteE = 0; RdE = 5'd3; ResultSrcE = 2'b00;
      PC = 32'h40; PCPlus4 = 32'h44;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      #1;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.ALUResultM", ALUResultM, 32'd0);
      chk("rst.WriteDataM", WriteDataM, 32'd0);
      chk("rst.PCPlus4M", PCPlus4M, 32'd0);
      chk("rst.RdM", 32'(RdM), 32'd0);
      chk("rst.RegWriteM", 32'(RegWriteM), 32'd0);
      chk("rst.MemWriteM", 32'(MemWriteM), 32'd0);
      chk("rst.ResultSrcM", 32'(ResultSrcM), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // add with immediate
      op(3'b000, 32'd5, 32'd0, 32'd7, 1'b1);
      step("add");
      chk("add.direct", ALUResultM, 32'd12);
      chk("add.valid", 32'(out_valid), 32'd1);

      // signed set-less-than and wrapping subtract
      op(3'b101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      step("slt");
      chk("slt.direct", ALUResultM, 32'd1);
      op(3'b001, 32'd3, 32'd5, 32'd0, 1'b0);
      step("sub");
      chk("sub.direct", ALUResultM, 32'hFFFF_FFFE);

      // taken branch, then the same branch flushed
      op(3'b001, 32'd9, 32'd9, 32'h20, 1'b0);
      BranchE = 1; PC = 32'h100; RegWriteE = 0;
      #1;
      chk("beq.PCSrcE", 32'(PCSrcE), 32'd1);
      chk("beq.PCTargetE", PCTargetE, 32'h120);
      step("beq");
      flush = 1;
      #1;
      chk("beqf.PCSrcE", 32'(PCSrcE), 32'd0);
      step("beqf");
      chk("beqf.valid", 32'(out_valid), 32'd0);

      // forwarding from MEM and WB
      op(3'b000, 32'd40, 32'd0, 32'd0, 1'b1);
      step("fwd0");
      op(3'b011, 32'hDEAD, 32'hBEEF, 32'd0, 1'b0);
      ForwardA = 2'b10; ForwardB = 2'b01; ResultW = 32'd2;
      step("fwd1");
      chk("fwd.direct", ALUResultM, 32'd42);
      chk("fwd.wdata", WriteDataM, 32'd2);

      // stall for three cycles with a pending instruction, then release
      op(3'b000, 32'd100, 32'd0, 32'd1, 1'b1);
      step("stall0");
      op(3'b010, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0);
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         step("stall");
         chk("stall.in_ready", 32'(in_ready), 32'd0);
         chk("stall.hold", ALUResultM, 32'd101);
      end
      out_ready = 1;
      step("release");
      chk("release.direct", ALUResultM, 32'h00F0);
      chk("release.valid", 32'(out_valid), 32'd1);

      // asynchronous reset in the middle of a stall
      op(3'b000, 32'd1, 32'd0, 32'd1, 1'b1);
      MemWriteE = 1;
      step("ar0");
      out_ready = 0;
      step("ar1");
      #2;
      rst_n = 0;
      #1;
      chk("areset.out_valid", 32'(out_valid), 32'd0);
      chk("areset.RegWriteM", 32'(RegWriteM), 32'd0);
      chk("areset.MemWriteM", 32'(MemWriteM), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      idle_inputs();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         in_valid   = ($urandom_range(3) != 0);
         flush      = ($urandom_range(7) == 0);
         out_ready  = ($urandom_range(2) != 0);
         ALUControl = 3'($urandom_range(7));
         ALUSrc     = 1'($urandom_range(1));
         ForwardA   = 2'($urandom_range(3));
         ForwardB   = 2'($urandom_range(3));
         if (!m_valid && ForwardA == 2'b10) ForwardA = 2'b00;
         if (!m_valid && ForwardB == 2'b10) ForwardB = 2'b00;
         RD1        = ($urandom_range(1) == 0) ? 32'($urandom_range(15)) : $urandom;
         RD2        = ($urandom_range(3) == 0) ? RD1 : $urandom;
         ImmExt     = $urandom;
         PC         = $urandom;
         PCPlus4    = PC + 32'd4;
         ResultW    = $urandom;
         RdE        = 5'($urandom_range(31));
         RegWriteE  = 1'($urandom_range(1));
         MemWriteE  = 1'($urandom_range(1));
         BranchE    = 1'($urandom_range(1));
         JumpE      = ($urandom_range(5) == 0);
         ResultSrcE = 2'($urandom_range(3));
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
